fb_scan_reader: RTL and testbench

- Display-side fetch stage between the 320x240 3-bit framebuffer Memory read port and the VGA output/DAC path.
- Generates 640x480@60 timing from the 50 MHz system clock. Each framebuffer pixel is shown as a 2x2 block.
- Drives the framebuffer read address (XRead/YRead) and absorbs the memory's 1-clk read latency.
- Emits sync, blank and 8-bit RGB, all aligned to the same pixel.

---
 rtl/fb_scan_reader.sv | 114 +++++++++++
 tb/tb_fb_scan_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: display fetch stage for a 3-bit framebuffer.
// Generates 640x480@60 raster timing from a 2:1 divided system clock.
// Each framebuffer pixel is shown as a 2x2 block. The block addresses
// the framebuffer read port, absorbs its one-clock read latency, and
// emits sync, blank and RGB aligned to the same pixel.
module fb_scan_reader #(
  parameter int ImageWidth  = 320,
  parameter int ImageHeight = 240,
  parameter int ColorBits   = 3,
  parameter int HVisible    = 640,
  parameter int HFront      = 16,
  parameter int HSync       = 96,
  parameter int HBack       = 48,
  parameter int VVisible    = 480,
  parameter int VFront      = 10,
  parameter int VSync       = 2,
  parameter int VBack       = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ColorBits-1:0] readValueMemory,
  output logic [8:0]           XRead,
  output logic [7:0]           YRead,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue,
  output logic                 clkVGA,
  output logic                 frameStart
);

  // Raster boundaries, sized to the counters so every compare is 10-bit.
  localparam logic [9:0] H_VIS        = 10'(HVisible);
  localparam logic [9:0] H_SYNC_START = 10'(HVisible + HFront);
  localparam logic [9:0] H_SYNC_END   = 10'(HVisible + HFront + HSync);
  localparam logic [9:0] H_LAST       = 10'(HVisible + HFront + HSync + HBack - 1);
  localparam logic [9:0] V_VIS        = 10'(VVisible);
  localparam logic [9:0] V_SYNC_START = 10'(VVisible + VFront);
  localparam logic [9:0] V_SYNC_END   = 10'(VVisible + VFront + VSync);
  localparam logic [9:0] V_LAST       = 10'(VVisible + VFront + VSync + VBack - 1);
  localparam logic [9:0] X_LIM        = 10'(ImageWidth);
  localparam logic [9:0] Y_LIM        = 10'(ImageHeight);

  logic       tick;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       visible;
  logic       h_wrap;
  logic       v_wrap;

  // Visible-region decode and framebuffer address, held for both clocks of a pixel.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // can leave it unassigned and no latch is inferred.
    XRead   = '0;
    YRead   = '0;
    visible = (h_count < H_VIS) && (v_count < V_VIS);
    h_wrap  = (h_count == H_LAST);
    v_wrap  = (v_count == V_LAST);
    // The extra bound keeps the address inside the image even if the
    // timing and image parameters were ever set inconsistently.
    if (visible && ({1'b0, h_count[9:1]} < X_LIM) && ({1'b0, v_count[9:1]} < Y_LIM)) begin
      XRead = h_count[9:1];
      YRead = v_count[8:1];
    end
  end

  // Pixel-rate divider, raster counters and start-of-frame pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, e.g. frameStart sees the pre-wrap counters.
    if (!reset) begin
      tick       <= 1'b0;
      clkVGA     <= 1'b0;
      h_count    <= '0;
      v_count    <= '0;
      frameStart <= 1'b0;
    end else begin
      tick       <= ~tick;
      clkVGA     <= ~tick;
      frameStart <= tick && h_wrap && v_wrap;
      if (tick) begin
        if (h_wrap) begin
          h_count <= '0;
          v_count <= v_wrap ? 10'd0 : v_count + 10'd1;
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  // Output stage: one pixel behind the counters, matching the read latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      blank <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (tick) begin
      hsync <= !((h_count >= H_SYNC_START) && (h_count < H_SYNC_END));
      vsync <= !((v_count >= V_SYNC_START) && (v_count < V_SYNC_END));
      blank <= visible;
      red   <= visible ? {8{readValueMemory[2]}} : 8'h00;
      green <= visible ? {8{readValueMemory[1]}} : 8'h00;
      blue  <= visible ? {8{readValueMemory[0]}} : 8'h00;
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: scoreboard bench for fb_scan_reader.
// Two instances share clock and reset: one with full 640x480 timing for
// line-level behaviour, one with a shrunken raster so whole frames fit
// in a short run. Expected outputs come from the count of clocks since
// reset release, converted to raster positions with plain arithmetic.
module tb_fb_scan_reader;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       cv;
    logic       fs;
  } exp_t;

  // Raster geometry: totals, visible extents and sync windows.
  typedef struct packed {
    int ht; int vt; int hv; int hss; int hse; int vv; int vss; int vse;
  } tm_t;

  localparam tm_t BIG   = '{800, 525, 640, 656, 752, 480, 490, 492};
  localparam tm_t SMALL = '{50, 19, 32, 36, 44, 12, 14, 16};

  logic clk;
  logic reset;

  logic [2:0] fb_big   [240][320];
  logic [2:0] fb_small [6][16];
  logic [2:0] rd_big, rd_small;

  logic [8:0] x_big, x_small;
  logic [7:0] y_big, y_small;
  logic       hs_big, vs_big, bl_big, cv_big, fs_big;
  logic       hs_small, vs_small, bl_small, cv_small, fs_small;
  logic [7:0] r_big, g_big, b_big, r_small, g_small, b_small;

  int   checks = 0;
  int   errors = 0;
  int   n      = 0;
  bit   armed  = 0;
  exp_t q_big[$];
  exp_t q_small[$];

  fb_scan_reader dut_big (
    .clk(clk), .reset(reset), .readValueMemory(rd_big),
    .XRead(x_big), .YRead(y_big), .hsync(hs_big), .vsync(vs_big), .blank(bl_big),
    .red(r_big), .green(g_big), .blue(b_big), .clkVGA(cv_big), .frameStart(fs_big)
  );

  fb_scan_reader #(
    .ImageWidth(16), .ImageHeight(6),
    .HVisible(32), .HFront(4), .HSync(8), .HBack(6),
    .VVisible(12), .VFront(2), .VSync(2), .VBack(3)
  ) dut_small (
    .clk(clk), .reset(reset), .readValueMemory(rd_small),
    .XRead(x_small), .YRead(y_small), .hsync(hs_small), .vsync(vs_small), .blank(bl_small),
    .red(r_small), .green(g_small), .blue(b_small), .clkVGA(cv_small), .frameStart(fs_small)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Framebuffer read ports with one clock of latency.
  always @(posedge clk) begin
    rd_big   <= fb_big[y_big][x_big];
    rd_small <= fb_small[y_small][x_small];
  end

  // Expected outputs after the k-th clock edge since reset (k=0 is the reset edge).
  function automatic exp_t model(int k, tm_t t, bit big);
    exp_t e;
    int q, h, v, m, p, hp, vp;
    logic [2:0] code;
    e    = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (k == 0) return e;
    e.cv = (k % 2) == 1;
    // Raster position currently driving the address.
    q = k / 2;
    h = q % t.ht;
    v = (q / t.ht) % t.vt;
    if (h < t.hv && v < t.vv) begin
      e.x = 9'(h / 2);
      e.y = 8'(v / 2);
    end
    // Output registers show the pixel before the most recent pixel tick.
    m = k - (k % 2);
    if (m > 0) begin
      p  = m / 2 - 1;
      hp = p % t.ht;
      vp = (p / t.ht) % t.vt;
      e.hs = !(hp >= t.hss && hp < t.hse);
      e.vs = !(vp >= t.vss && vp < t.vse);
      e.bl = (hp < t.hv) && (vp < t.vv);
      if (e.bl) begin
        if (big) code = fb_big[vp / 2][hp / 2];
        else     code = fb_small[vp / 2][hp / 2];
        e.r = {8{code[2]}};
        e.g = {8{code[1]}};
        e.b = {8{code[0]}};
      end
    end
    e.fs = ((k % 2) == 0) && (((k / 2) % (t.ht * t.vt)) == 0);
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b bl=%b rgb=%h/%h/%h cv=%b fs=%b",
                     e.x, e.y, e.hs, e.vs, e.bl, e.r, e.g, e.b, e.cv, e.fs);
  endfunction

  task automatic check(string name, int k, exp_t act, exp_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s edge=%0d got %s want %s", name, k, fmt(act), fmt(want));
    end
  endtask

  // Stimulus side of the scoreboard: predict each edge's outputs.
  always @(posedge clk) begin
    if (!reset) begin
      n     = 0;
      armed = 1;
    end else begin
      n = n + 1;
    end
    if (armed) begin
      q_big.push_back(model(n, BIG, 1'b1));
      q_small.push_back(model(n, SMALL, 1'b0));
    end
  end

  // Monitor: compare what each DUT presents against the predicted entry.
  always @(negedge clk) begin
    exp_t want, act;
    if (q_big.size() > 0) begin
      want = q_big.pop_front();
      act  = '{x_big, y_big, hs_big, vs_big, bl_big, r_big, g_big, b_big, cv_big, fs_big};
      check("big", n, act, want);
    end
    if (q_small.size() > 0) begin
      want = q_small.pop_front();
      act  = '{x_small, y_small, hs_small, vs_small, bl_small,
               r_small, g_small, b_small, cv_small, fs_small};
      check("small", n, act, want);
    end
  end

  initial begin
    reset = 1'b0;
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 320; x++)
        fb_big[y][x] = 3'($urandom_range(0, 7));
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 16; x++)
        fb_small[y][x] = 3'($urandom_range(0, 7));
    // Pin the corners to distinct codes so the extremes are exercised.
    fb_small[0][0]  = 3'd5;
    fb_small[5][15] = 3'd6;
    fb_big[0][0]    = 3'd3;

    repeat (5) @(negedge clk);
    reset = 1'b1;
    // ~28 full-timing lines and ~23 shrunken frames.
    repeat (45000) @(negedge clk);

    // Single-clock resets at random points mid-line and mid-frame.
    for (int i = 0; i < 4; i++) begin
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(2000, 9000)) @(negedge clk);
    end
    // Long tail after the last reset to see the next full frame boundary.
    repeat (4000) @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
